// File: rtl/cpu_types_pkg.sv
// Types and helpers shared by the cache/RAM layer: arbiter FSM states and
// the requester index mapping for each core's icache/dcache pair.
package cpu_types_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  // Requester 2c is the icache of core c; 2c+1 is its dcache.
  function automatic int unsigned ICACHE_REQ(input int unsigned c);
    return 2 * c;
  endfunction

  function automatic int unsigned DCACHE_REQ(input int unsigned c);
    return 2 * c + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: the first pending index scanning last_grant+1,
// last_grant+2, ... modulo NREQ. Purely combinational.
module rr_priority_select #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   last_grant,
  output logic            any,
  output logic [IW-1:0]   winner
);

  logic [IW-1:0] idx;

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IW'((int'(last_grant) + off) % NREQ);
      if (!any && pending[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port among NREQ cache requesters with a non-preemptive
// round-robin arbiter; each grant is latched and held until ram_ready.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*AW-1:0] req_store,
  output logic [NREQ-1:0]    req_ack,
  output logic [AW-1:0]      req_load,
  output logic               busy,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [AW-1:0]      ramaddr,
  output logic [AW-1:0]      ramstore,
  input  logic [AW-1:0]      ramload,
  input  logic               ram_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          op_q, op_d;          // 1 = write
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] store_q, store_d;

  logic [NREQ-1:0] pending;
  logic            any_pending;
  logic [IW-1:0]   winner;
  logic            done;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [AW-1:0] store_arr [NREQ];

  assign pending = req_ren | req_wen;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AW +: AW];
    assign store_arr[i] = req_store[i*AW +: AW];
  end

  rr_priority_select #(.NREQ(NREQ)) u_select (
    .pending    (pending),
    .last_grant (last_grant_q),
    .any        (any_pending),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    addr_d       = addr_q;
    store_d      = store_q;
    unique case (state_q)
      IDLE: begin
        if (any_pending) begin
          owner_d = winner;
          op_d    = req_wen[winner];  // write wins over a simultaneous read
          addr_d  = addr_arr[winner];
          store_d = store_arr[winner];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (ram_ready) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      owner_q      <= '0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      store_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
    end
  end

  // RAM port is driven only from latched fields, so reset drops the enables
  // immediately and requester inputs never reach it combinationally.
  assign busy     = (state_q == ACCESS);
  assign ramREN   = busy & ~op_q;
  assign ramWEN   = busy & op_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  assign done     = busy & ram_ready;
  assign req_load = (done && !op_q) ? ramload : '0;
  assign req_ack  = (done && pending[owner_q]) ? (NREQ'(1) << owner_q) : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a table of single transactions
// exercising round-robin order, followed by hand-written multi-cycle cases.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 32;

  logic              CLK;
  logic              nRST;
  logic [NREQ-1:0]   req_ren;
  logic [NREQ-1:0]   req_wen;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*AW-1:0] req_store;
  logic [NREQ-1:0]   req_ack;
  logic [AW-1:0]     req_load;
  logic              busy;
  logic              ramREN;
  logic              ramWEN;
  logic [AW-1:0]     ramaddr;
  logic [AW-1:0]     ramstore;
  logic [AW-1:0]     ramload;
  logic              ram_ready;

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_store (req_store),
    .req_ack   (req_ack),
    .req_load  (req_load),
    .busy      (busy),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ram_ready (ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [NREQ-1:0] ren;
    logic [NREQ-1:0] wen;
    int              owner;
    logic            op;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [31:0] v);
    req_addr[i*AW +: AW] = v;
  endtask

  task automatic set_store(input int i, input logic [31:0] v);
    req_store[i*AW +: AW] = v;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] exp_ack;
    int o;

    nRST      = 1'b1;
    req_ren   = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_store = '0;
    ramload   = '0;
    ram_ready = 1'b0;
    #1 nRST = 1'b0;
    #1;
    check("rst req_ack",  32'(req_ack), 32'h0);
    check("rst req_load", req_load, 32'h0);
    check("rst busy",     32'(busy), 32'h0);
    check("rst ramREN",   32'(ramREN), 32'h0);
    check("rst ramWEN",   32'(ramWEN), 32'h0);
    check("rst ramaddr",  ramaddr, 32'h0);
    check("rst ramstore", ramstore, 32'h0);
    #10 nRST = 1'b1;
    step();

    // Table: one transaction per row, ram_ready in the first ACCESS cycle.
    // last_grant starts at 3; expected owners follow the round-robin scan.
    tbl[0] = '{ren: 4'b0110, wen: 4'b0000, owner: 1, op: 1'b0};
    tbl[1] = '{ren: 4'b0011, wen: 4'b0000, owner: 0, op: 1'b0};
    tbl[2] = '{ren: 4'b1000, wen: 4'b0010, owner: 1, op: 1'b1};
    tbl[3] = '{ren: 4'b0001, wen: 4'b1000, owner: 3, op: 1'b1};
    tbl[4] = '{ren: 4'b0100, wen: 4'b0100, owner: 2, op: 1'b1};
    tbl[5] = '{ren: 4'b1111, wen: 4'b0000, owner: 3, op: 1'b0};
    tbl[6] = '{ren: 4'b1111, wen: 4'b0000, owner: 0, op: 1'b0};
    tbl[7] = '{ren: 4'b0000, wen: 4'b0001, owner: 0, op: 1'b1};

    for (int i = 0; i < NREQ; i++) begin
      set_addr(i, 32'h1000 + 32'(i) * 32'h10);
      set_store(i, 32'h5000_0000 + 32'(i));
    end

    for (int v = 0; v < 8; v++) begin
      req_ren = tbl[v].ren;
      req_wen = tbl[v].wen;
      ramload = 32'h7700_0000 + 32'(v);
      @(negedge CLK);
      check($sformatf("v%0d idle busy", v), 32'(busy), 32'h0);
      check($sformatf("v%0d idle enables", v), {30'h0, ramREN, ramWEN}, 32'h0);
      step();
      ram_ready = 1'b1;
      @(negedge CLK);
      o = tbl[v].owner;
      exp_ack = 4'b0001 << o;
      check($sformatf("v%0d ramREN", v), 32'(ramREN), 32'(!tbl[v].op));
      check($sformatf("v%0d ramWEN", v), 32'(ramWEN), 32'(tbl[v].op));
      check($sformatf("v%0d ramaddr", v), ramaddr, 32'h1000 + 32'(o) * 32'h10);
      check($sformatf("v%0d ramstore", v), ramstore, 32'h5000_0000 + 32'(o));
      check($sformatf("v%0d req_ack", v), 32'(req_ack), 32'(exp_ack));
      check($sformatf("v%0d req_load", v), req_load,
            tbl[v].op ? 32'h0 : 32'h7700_0000 + 32'(v));
      step();
      ram_ready = 1'b0;
      req_ren   = '0;
      req_wen   = '0;
    end

    // Read by dcache of core 0, RAM ready two cycles into ACCESS.
    set_addr(DCACHE_REQ(0), 32'h100);
    req_ren[DCACHE_REQ(0)] = 1'b1;
    ramload = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("t1 c0 ramREN", 32'(ramREN), 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) ram_ready = 1'b1;
      @(negedge CLK);
      check($sformatf("t1 c%0d ramREN", c), 32'(ramREN), 32'h1);
      check($sformatf("t1 c%0d ramaddr", c), ramaddr, 32'h100);
      check($sformatf("t1 c%0d req_ack", c), 32'(req_ack), (c == 3) ? 32'h2 : 32'h0);
    end
    check("t1 req_load", req_load, 32'hDEAD_BEEF);
    step();
    ram_ready = 1'b0;
    req_ren   = '0;
    @(negedge CLK);
    check("t1 idle busy", 32'(busy), 32'h0);
    check("t1 idle ack", 32'(req_ack), 32'h0);
    step();

    // Simultaneous ren and wen: the write wins and req_load stays 0.
    set_addr(3, 32'h40);
    set_store(3, 32'h1234_5678);
    req_ren[3] = 1'b1;
    req_wen[3] = 1'b1;
    ramload    = 32'hCAFE_F00D;
    step();
    ram_ready = 1'b1;
    @(negedge CLK);
    check("t3 ramWEN", 32'(ramWEN), 32'h1);
    check("t3 ramREN", 32'(ramREN), 32'h0);
    check("t3 ramaddr", ramaddr, 32'h40);
    check("t3 ramstore", ramstore, 32'h1234_5678);
    check("t3 req_ack", 32'(req_ack), 32'h8);
    check("t3 req_load", req_load, 32'h0);
    step();
    ram_ready = 1'b0;
    req_ren   = '0;
    req_wen   = '0;

    // Requester 2 drops mid-access: no ack, but last_grant still moves to 2,
    // so 3 wins over 0 on the next arbitration.
    set_addr(2, 32'h220);
    set_addr(3, 32'h333);
    set_addr(0, 32'h000);
    req_ren[2] = 1'b1;
    step();
    req_ren[2] = 1'b0;
    req_ren[3] = 1'b1;
    req_ren[0] = 1'b1;
    @(negedge CLK);
    check("t4 ramaddr", ramaddr, 32'h220);
    check("t4 ack early", 32'(req_ack), 32'h0);
    step();
    ram_ready = 1'b1;
    @(negedge CLK);
    check("t4 ramREN at ready", 32'(ramREN), 32'h1);
    check("t4 ack suppressed", 32'(req_ack), 32'h0);
    step();
    ram_ready = 1'b0;
    @(negedge CLK);
    check("t4 bubble busy", 32'(busy), 32'h0);
    step();
    ram_ready = 1'b1;
    @(negedge CLK);
    check("t4 next ramaddr", ramaddr, 32'h333);
    check("t4 next ack", 32'(req_ack), 32'h8);
    step();
    ram_ready = 1'b0;
    req_ren   = '0;

    // Address changes mid-access do not reach the RAM port.
    set_addr(0, 32'h200);
    req_ren[0] = 1'b1;
    step();
    set_addr(0, 32'h300);
    @(negedge CLK);
    check("t5 ramaddr c1", ramaddr, 32'h200);
    step();
    @(negedge CLK);
    check("t5 ramaddr c2", ramaddr, 32'h200);
    step();
    ram_ready = 1'b1;
    @(negedge CLK);
    check("t5 ramaddr done", ramaddr, 32'h200);
    check("t5 req_ack", 32'(req_ack), 32'h1);
    step();
    ram_ready = 1'b0;
    req_ren   = '0;

    // Fairness from reset: all reading, ram_ready held high.
    pulse_reset();
    step();
    ramload   = 32'hA5A5_0000;
    ram_ready = 1'b1;
    req_ren   = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      exp_ack = (k % 2 == 1) ? (4'b0001 << ((k / 2) % 4)) : 4'b0000;
      check($sformatf("t2 k%0d req_ack", k), 32'(req_ack), 32'(exp_ack));
      if (k % 2 == 1) check($sformatf("t2 k%0d req_load", k), req_load, 32'hA5A5_0000);
      step();
    end
    req_ren   = '0;
    ram_ready = 1'b0;
    step();

    // Reset during a write access drops the enables at once; afterwards
    // requester 0 has priority over requester 1 again.
    set_addr(1, 32'h500);
    req_wen[1] = 1'b1;
    step();
    @(negedge CLK);
    check("t6 ramWEN before", 32'(ramWEN), 32'h1);
    #1 nRST = 1'b0;
    #1;
    check("t6 enables in reset", {30'h0, ramREN, ramWEN}, 32'h0);
    check("t6 busy in reset", 32'(busy), 32'h0);
    check("t6 ack in reset", 32'(req_ack), 32'h0);
    set_addr(0, 32'h600);
    req_ren[0] = 1'b1;
    #1 nRST = 1'b1;
    step();
    @(negedge CLK);
    check("t6 ramREN after", 32'(ramREN), 32'h1);
    check("t6 ramaddr after", ramaddr, 32'h600);
    ram_ready = 1'b1;
    #1;
    check("t6 req_ack", 32'(req_ack), 32'h1);
    step();
    ram_ready = 1'b0;
    req_ren   = '0;
    req_wen   = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
